// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data requesters.
// Data wins by default, but never more than MAX_STREAK grants in a row while fetch waits.
// Optional build macro ARB_STATS_EN adds grant and wait-cycle counters.
module mem_port_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int MEM_LATENCY = 1,
   parameter int MAX_STREAK  = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_ack_o,
   output logic [DW-1:0] if_rdata_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [DW-1:0] d_wdata_i,
   output logic          d_ack_o,
   output logic [DW-1:0] d_rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          stall_o
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]   stat_if_grants_o,
   output logic [31:0]   stat_d_grants_o,
   output logic [31:0]   stat_wait_cycles_o
`endif
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SW = $clog2(MAX_STREAK + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q;
   logic          owner_q;           // 1 = data requester owns the port
   logic          we_q;
   logic [CW-1:0] wait_cnt_q;
   logic [SW-1:0] streak_q, streak_d;
   logic          if_ack_q, d_ack_q;
   logic          mem_en_q, mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] if_rdata_q, d_rdata_q;
   logic          any_req;
   logic          grant_data;

   always_comb begin
      any_req    = if_req_i | d_req_i;
      grant_data = d_req_i && !(if_req_i && (streak_q == SW'(MAX_STREAK)));
      streak_d   = '0;
      if (grant_data && if_req_i)
         streak_d = (streak_q == SW'(MAX_STREAK)) ? streak_q : streak_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         wait_cnt_q  <= '0;
         streak_q    <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q    <= grant_data;
                  we_q       <= grant_data & d_we_i;
                  streak_q   <= streak_d;
                  mem_en_q   <= 1'b1;
                  mem_we_q   <= grant_data & d_we_i;
                  mem_addr_q <= grant_data ? d_addr_i : if_addr_i;
                  if (grant_data)
                     mem_wdata_q <= d_wdata_i;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en_q   <= 1'b0;
               mem_we_q   <= 1'b0;
               wait_cnt_q <= '0;
               if (we_q) begin
                  d_ack_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // mem_rdata is valid only in the last WAIT cycle
               if (wait_cnt_q == CW'(MEM_LATENCY - 1)) begin
                  if (owner_q) begin
                     d_rdata_q <= mem_rdata_i;
                     d_ack_q   <= 1'b1;
                  end else begin
                     if_rdata_q <= mem_rdata_i;
                     if_ack_q   <= 1'b1;
                  end
                  state_q <= RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            RESP: begin
               if_ack_q <= 1'b0;
               d_ack_q  <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_ack_o    = if_ack_q;
   assign d_ack_o     = d_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

`ifdef ARB_STATS_EN
   logic [31:0] stat_if_q, stat_d_q, stat_wait_q;
   logic        waiting;

   // A requester waits when it is not the owner, or anyone is pending in IDLE
   always_comb begin
      waiting = 1'b0;
      if (state_q == IDLE)
         waiting = any_req;
      else
         waiting = (if_req_i & owner_q) | (d_req_i & ~owner_q);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stat_if_q   <= '0;
         stat_d_q    <= '0;
         stat_wait_q <= '0;
      end else begin
         if (state_q == IDLE && any_req) begin
            if (grant_data) stat_d_q  <= stat_d_q + 32'd1;
            else            stat_if_q <= stat_if_q + 32'd1;
         end
         if (waiting)
            stat_wait_q <= stat_wait_q + 32'd1;
      end
   end

   assign stat_if_grants_o   = stat_if_q;
   assign stat_d_grants_o    = stat_d_q;
   assign stat_wait_cycles_o = stat_wait_q;
`endif

endmodule
